// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and the slave-side FSM state set.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    // One-hot, matching the other bus FSMs in the codebase.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RD    = 4'b0010,
        S_WR    = 4'b0100,
        S_WRESP = 4'b1000
    } slv_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between a master and the SRAM slave responder.
interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_sram_slave_sram_1p.sv
// Single-port 32-bit SRAM with byte write enables and one-cycle registered read.
module sram_1p #(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // q only moves on a read, so it doubles as the R-channel hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 32'd0;
        end else if (en && !we) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave that runs one read or write burst at a time against a single-port SRAM.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic            aclk,
    input  logic            areset,
    axi_sram_slave_if.slave bus
);

    slv_state_t  state, state_nxt;
    logic        alive;
    logic        prio_rd;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic [8:0]  beat_cnt;
    logic        werr_q;

    logic        vld_p1;
    logic        rlast_p1;
    resp_t       rresp_p1;
    logic [3:0]  rid_q;
    logic        bvalid_q;
    resp_t       bresp_q;
    logic [3:0]  bid_q;

    logic        arready_c, awready_c, wready_c;
    logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic        addr_oor, beat_is_last, rd_remain, rd_issue, werr_nxt;
    logic [31:0] sram_q;
    logic        unused_sig;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
        return (b == BURST_FIXED) ? a : a + 32'd4;
    endfunction

    assign addr_oor     = |addr_q[31:MEM_AW+2];
    assign beat_is_last = (beat_cnt == {1'b0, len_q});
    assign rd_remain    = (state == S_RD) && (beat_cnt <= {1'b0, len_q});
    assign rd_issue     = rd_remain && (!vld_p1 || bus.rready);

    assign ar_hs = bus.arvalid && arready_c;
    assign aw_hs = bus.awvalid && awready_c;
    assign r_hs  = vld_p1 && bus.rready;
    assign w_hs  = bus.wvalid && wready_c;
    assign b_hs  = bvalid_q && bus.bready;

    assign werr_nxt = werr_q | addr_oor | (bus.wlast != beat_is_last);

    always_comb begin
        state_nxt = state;
        arready_c = 1'b0;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        unique case (state)
            S_IDLE: begin
                arready_c = alive && (!bus.awvalid || prio_rd);
                awready_c = alive && (!bus.arvalid || !prio_rd);
                if (bus.arvalid && arready_c) begin
                    state_nxt = S_RD;
                end else if (bus.awvalid && awready_c) begin
                    state_nxt = S_WR;
                end
            end
            S_RD: begin
                if (r_hs && rlast_p1) state_nxt = S_IDLE;
            end
            S_WR: begin
                wready_c = 1'b1;
                if (bus.wvalid && beat_is_last) state_nxt = S_WRESP;
            end
            S_WRESP: begin
                if (b_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state and response registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= S_IDLE;
            alive    <= 1'b0;
            prio_rd  <= 1'b1;
            beat_cnt <= 9'd0;
            werr_q   <= 1'b0;
            vld_p1   <= 1'b0;
            rlast_p1 <= 1'b0;
            rresp_p1 <= RESP_OKAY;
            rid_q    <= 4'd0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            bid_q    <= 4'd0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            if (ar_hs) begin
                prio_rd  <= 1'b0;
                rid_q    <= bus.arid;
                beat_cnt <= 9'd0;
            end else if (aw_hs) begin
                prio_rd  <= 1'b1;
                bid_q    <= bus.awid;
                beat_cnt <= 9'd0;
                werr_q   <= 1'b0;
            end
            if (rd_issue) begin
                beat_cnt <= beat_cnt + 9'd1;
                vld_p1   <= 1'b1;
                rlast_p1 <= beat_is_last;
                rresp_p1 <= addr_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                vld_p1   <= 1'b0;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
                werr_q   <= werr_nxt;
                if (beat_is_last) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= werr_nxt ? RESP_SLVERR : RESP_OKAY;
                end
            end
            if (b_hs) bvalid_q <= 1'b0;
        end
    end

    // Burst address datapath.
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            addr_q  <= bus.araddr;
            len_q   <= bus.arlen;
            burst_q <= bus.arburst;
        end else if (aw_hs) begin
            addr_q  <= bus.awaddr;
            len_q   <= bus.awlen;
            burst_q <= bus.awburst;
        end else if (rd_issue || w_hs) begin
            addr_q  <= next_addr(addr_q, burst_q);
        end
    end

    sram_1p #(.MEM_AW(MEM_AW)) u_sram (
        .clk   (aclk),
        .rst   (areset),
        .en    (rd_issue || (w_hs && !addr_oor)),
        .we    (w_hs),
        .be    (bus.wstrb),
        .addr  (addr_q[MEM_AW+1:2]),
        .wdata (bus.wdata),
        .q     (sram_q)
    );

    assign bus.arready = arready_c;
    assign bus.awready = awready_c;
    assign bus.wready  = wready_c;
    assign bus.rvalid  = vld_p1;
    assign bus.rlast   = rlast_p1;
    assign bus.rresp   = rresp_p1;
    assign bus.rid     = rid_q;
    assign bus.rdata   = (rresp_p1 == RESP_SLVERR) ? 32'd0 : sram_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

    assign unused_sig = ^{bus.arsize, bus.arlock, bus.arcache, bus.arprot,
                          bus.awsize, bus.awlock, bus.awcache, bus.awprot,
                          bus.wid, addr_q[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: writes, reads, strobes, bursts, arbitration, errors, reset.
module tb_axi_sram_slave;

    localparam int MEM_AW = 16;
    localparam logic [31:0] OOR_ADDR = 32'h1 << (MEM_AW + 2);

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    int          rd_n;
    logic [1:0]  resp;
    logic [3:0]  bid_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit early_last,
                            output logic [1:0] bresp_o, output logic [3:0] bid_r);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
        bus.awsize = 3'd2; bus.awvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.awready && n < 20) begin @(negedge aclk); n++; end
        if (n >= 20) check("aw_timeout", 32'd1, 32'd0);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        check("w_ready_t1", 32'(bus.wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
            bus.wlast = (i == int'(len)) || (early_last && i == 0);
            bus.wvalid = 1'b1;
            #1;
            n = 0;
            while (!bus.wready && n < 20) begin @(negedge aclk); n++; end
            if (n >= 20) check("w_timeout", 32'd1, 32'd0);
            @(negedge aclk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("b_latency", 32'(bus.bvalid), 32'd1);
        bresp_o = bus.bresp;
        bid_r = bus.bid;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check("b_clear", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        int n;
        int cyc;
        bit hold_pending;
        logic [31:0] held;
        rd_n = 0;
        hold_pending = 1'b0;
        held = 32'd0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arsize = 3'd2; bus.arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge aclk); n++; end
        if (n >= 20) check("ar_timeout", 32'd1, 32'd0);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        check("r_lat_t1", 32'(bus.rvalid), 32'd0);
        @(negedge aclk);
        check("r_lat_t2", 32'(bus.rvalid), 32'd1);
        cyc = 0;
        while (rd_n <= int'(len) && cyc < 200) begin
            bus.rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (hold_pending) begin
                check("r_hold", bus.rdata, held);
                hold_pending = 1'b0;
            end
            if (bus.rvalid && bus.rready) begin
                rd_data[rd_n] = bus.rdata; rd_resp[rd_n] = bus.rresp;
                rd_last[rd_n] = bus.rlast; rd_id[rd_n] = bus.rid;
                rd_n++;
            end else if (bus.rvalid) begin
                held = bus.rdata;
                hold_pending = 1'b1;
            end
            @(negedge aclk);
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", 32'(rd_n), 32'(int'(len) + 1));
        check("r_done", 32'(bus.rvalid), 32'd0);
        check("r_idle", 32'(bus.arready), 32'd1);
    endtask

    initial begin
        int n;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;

        repeat (3) @(negedge aclk);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rlast", 32'(bus.rlast), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ids", {24'd0, bus.rid, bus.bid}, 32'd0);
        check("rst_resps", {28'd0, bus.rresp, bus.bresp}, 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Arbitration straight out of reset: read wins, then write gets priority.
        bus.arid = 4'd3; bus.araddr = 32'h10; bus.arlen = 0; bus.arburst = 2'b01;
        bus.awid = 4'd4; bus.awaddr = 32'h30; bus.awlen = 0; bus.awburst = 2'b01;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.rready = 1'b1;
        #1;
        check("arb_arready", 32'(bus.arready), 32'd1);
        check("arb_awready", 32'(bus.awready), 32'd0);
        @(negedge aclk);
        check("arb_busy_ar", 32'(bus.arready), 32'd0);
        check("arb_busy_aw", 32'(bus.awready), 32'd0);
        @(negedge aclk);
        check("arb_rvalid", 32'(bus.rvalid), 32'd1);
        check("arb_rid", 32'(bus.rid), 32'd3);
        check("arb_rlast", 32'(bus.rlast), 32'd1);
        @(negedge aclk);
        check("arb_aw_next", 32'(bus.awready), 32'd1);
        check("arb_ar_next", 32'(bus.arready), 32'd0);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.rready = 1'b0;
        @(negedge aclk);

        // Single write then read back.
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(4'd1, 32'h10, 8'd0, 2'b01, 1'b0, resp, bid_o);
        check("w1_bid", 32'(bid_o), 32'd1);
        check("w1_bresp", 32'(resp), 32'd0);
        do_read(4'd2, 32'h10, 8'd0, 2'b01, 1'b0);
        check("r1_data", rd_data[0], 32'hDEADBEEF);
        check("r1_last", 32'(rd_last[0]), 32'd1);
        check("r1_rid", 32'(rd_id[0]), 32'd2);
        check("r1_resp", 32'(rd_resp[0]), 32'd0);

        // Byte strobes merge into the existing word.
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(4'd5, 32'h20, 8'd0, 2'b01, 1'b0, resp, bid_o);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(4'd6, 32'h20, 8'd0, 2'b01, 1'b0, resp, bid_o);
        do_read(4'd7, 32'h20, 8'd0, 2'b01, 1'b0);
        check("strb_data", rd_data[0], 32'h11BB33DD);

        // INCR burst written then read with rready toggling.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(4'd8, 32'h100, 8'd3, 2'b01, 1'b0, resp, bid_o);
        check("incr_bresp", 32'(resp), 32'd0);
        do_read(4'd9, 32'h100, 8'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_data%0d", i), rd_data[i], 32'(i + 1));
            check($sformatf("incr_last%0d", i), 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // Out-of-range beats and wlast disagreement.
        wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
        do_write(4'd1, 32'h0, 8'd0, 2'b01, 1'b0, resp, bid_o);
        do_read(4'd2, OOR_ADDR, 8'd0, 2'b01, 1'b0);
        check("oor_rresp", 32'(rd_resp[0]), 32'd2);
        check("oor_rdata", rd_data[0], 32'd0);
        wbuf[0] = 32'h55555555; sbuf[0] = 4'hF;
        do_write(4'd3, OOR_ADDR, 8'd0, 2'b01, 1'b0, resp, bid_o);
        check("oor_bresp", 32'(resp), 32'd2);
        do_read(4'd4, 32'h0, 8'd0, 2'b01, 1'b0);
        check("oor_mem_kept", rd_data[0], 32'h0BADF00D);
        check("inrange_rresp", 32'(rd_resp[0]), 32'd0);
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(4'd5, 32'h200, 8'd1, 2'b01, 1'b1, resp, bid_o);
        check("wlast_bresp", 32'(resp), 32'd2);

        // FIXED burst returns the same word twice.
        do_read(4'd6, 32'h10, 8'd1, 2'b00, 1'b0);
        check("fixed_d0", rd_data[0], 32'hDEADBEEF);
        check("fixed_d1", rd_data[1], 32'hDEADBEEF);
        check("fixed_last0", 32'(rd_last[0]), 32'd0);
        check("fixed_last1", 32'(rd_last[1]), 32'd1);

        // Reset during beat 2 of a len=7 read.
        bus.arid = 4'd9; bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        #1;
        @(negedge aclk);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge aclk);
            if (bus.rvalid) n++;
        end
        check("mid_beat2_seen", 32'(n), 32'd2);
        check("mid_beat2_data", bus.rdata, 32'd2);
        areset = 1'b1;
        #1;
        check("mid_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_rlast", 32'(bus.rlast), 32'd0);
        check("mid_readies", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd0);
        check("mid_bvalid", 32'(bus.bvalid), 32'd0);
        check("mid_rdata", bus.rdata, 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        check("mid_hold_rvalid", 32'(bus.rvalid), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("rel_arready", 32'(bus.arready), 32'd1);
        check("rel_no_beat", 32'(bus.rvalid), 32'd0);
        @(negedge aclk);
        check("rel_no_beat2", 32'(bus.rvalid), 32'd0);
        bus.rready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
